// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, frame totals and the region state encoding
// used by both the horizontal and vertical axis counters.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 16;

    function automatic int unsigned axis_total(
        input int unsigned visible,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return visible + front + sync + back;
    endfunction

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned DEF_H_TOTAL =
        axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int unsigned DEF_V_TOTAL =
        axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    // One region encoding serves both axes: ACTIVE/FRONT/SYNC/BACK.
    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } axis_state_t;

    typedef axis_state_t h_state_t;
    typedef axis_state_t v_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter, region FSM and registered sync output,
// all advancing together only on edges where i_step is high.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned VISIBLE     = DEF_H_VISIBLE,
    parameter int unsigned FRONT       = DEF_H_FRONT,
    parameter int unsigned SYNC        = DEF_H_SYNC,
    parameter int unsigned BACK        = DEF_H_BACK,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_step,
    output logic [CNT_W-1:0] o_count,
    output axis_state_t      o_state,
    output logic             o_sync
);

    localparam int unsigned      TOTAL     = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(VISIBLE - 1);
    localparam logic [CNT_W-1:0] FRT_LAST  = CNT_W'(VISIBLE + FRONT - 1);
    localparam logic [CNT_W-1:0] SYN_LAST  = CNT_W'(VISIBLE + FRONT + SYNC - 1);
    localparam logic [CNT_W-1:0] AXIS_LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] r_count;
    axis_state_t      r_state;
    logic             r_sync;

    // State changes on the edge that leaves the last count of its region, so
    // the region and sync level always line up with the same-cycle count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= AXIS_LAST;
            r_state <= ST_BACK;
            r_sync  <= ~SYNC_ACTIVE;
        end else if (i_step) begin
            r_count <= (r_count == AXIS_LAST) ? '0 : r_count + 1'b1;
            case (r_state)
                ST_ACTIVE: begin
                    if (r_count == ACT_LAST) r_state <= ST_FRONT;
                end
                ST_FRONT: begin
                    if (r_count == FRT_LAST) begin
                        r_state <= ST_SYNC;
                        r_sync  <= SYNC_ACTIVE;
                    end
                end
                ST_SYNC: begin
                    if (r_count == SYN_LAST) begin
                        r_state <= ST_BACK;
                        r_sync  <= ~SYNC_ACTIVE;
                    end
                end
                ST_BACK: begin
                    if (r_count == AXIS_LAST) r_state <= ST_ACTIVE;
                end
                default: begin
                    r_state <= ST_BACK;
                    r_sync  <= ~SYNC_ACTIVE;
                end
            endcase
        end
    end

    assign o_count = r_count;
    assign o_state = r_state;
    assign o_sync  = r_sync;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing generator: horizontal and vertical axis counters chained
// by line_end, with sync, video_on and frame_start decodes.
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT     = DEF_H_FRONT,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BACK      = DEF_H_BACK,
    parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic             clk_25Mhz,
    input  logic             rst_n,
    input  logic             enable,
    output logic [CNT_W-1:0] H_Count_Value,
    output logic [CNT_W-1:0] V_Count_Value,
    output logic             h_sync,
    output logic             v_sync,
    output logic             video_on,
    output logic             line_end,
    output logic             frame_start
);

    localparam int unsigned      H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);

    h_state_t w_h_state;
    v_state_t w_v_state;
    logic     w_line_end;
    logic     w_v_step;

    assign w_line_end = (H_Count_Value == H_LAST);
    assign w_v_step   = enable & w_line_end;

    vga_axis_counter #(
        .VISIBLE     (H_VISIBLE),
        .FRONT       (H_FRONT),
        .SYNC        (H_SYNC),
        .BACK        (H_BACK),
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_h_axis (
        .i_clk   (clk_25Mhz),
        .i_rst_n (rst_n),
        .i_step  (enable),
        .o_count (H_Count_Value),
        .o_state (w_h_state),
        .o_sync  (h_sync)
    );

    vga_axis_counter #(
        .VISIBLE     (V_VISIBLE),
        .FRONT       (V_FRONT),
        .SYNC        (V_SYNC),
        .BACK        (V_BACK),
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_v_axis (
        .i_clk   (clk_25Mhz),
        .i_rst_n (rst_n),
        .i_step  (w_v_step),
        .o_count (V_Count_Value),
        .o_state (w_v_state),
        .o_sync  (v_sync)
    );

    assign line_end    = w_line_end;
    assign video_on    = (w_h_state == ST_ACTIVE) && (w_v_state == ST_ACTIVE);
    assign frame_start = enable && (H_Count_Value == '0) && (V_Count_Value == '0);

endmodule
